// File: rtl/jit_vec_pkg.sv
// Shared types for the JIT vector pipeline: packed result word as produced by the pipe.
package jit_vec_pkg;

  localparam int JIT_VEC_W       = 25;
  localparam int JIT_VEC_TAG_BIT = 24;

  typedef struct packed {
    logic        tag;
    logic [15:0] data;
    logic [7:0]  lo8;
  } jit_vec_res_t;

endpackage

// File: rtl/jit_vec_sat_cnt.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module jit_vec_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/jit_vec_result_sink.sv
// Result sink for the JIT vector pipe: non-stalling capture FIFO with valid/ready output
// plus tag-hit count, running data sum and drop count.
module jit_vec_result_sink
  import jit_vec_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int LO_W   = 8,
  parameter int CNT_W  = 16,
  parameter int SUM_W  = 24
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     in_valid,
  input  logic                     in_tag,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [LO_W-1:0]          in_lo8,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_tag,
  output logic [DATA_W-1:0]        out_data,
  output logic [LO_W-1:0]          out_lo8,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  input  logic                     clr,
  output logic [CNT_W-1:0]         tag_cnt,
  output logic [SUM_W-1:0]         sum,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [LW-1:0]  r_level;
  logic [SUM_W-1:0] r_sum;
  jit_vec_res_t   r_mem [DEPTH];

  logic           w_pop;
  logic           w_push;
  jit_vec_res_t   w_in;
  jit_vec_res_t   w_head;

  assign empty  = (r_level == '0);
  assign full   = (r_level == LW'(DEPTH));
  assign level  = r_level;

  // A pop while full frees the slot the same-cycle push lands in (wr == rd then).
  assign w_pop  = ~empty & out_ready;
  assign w_push = in_valid & (~full | w_pop);

  assign w_in.tag  = in_tag;
  assign w_in.data = in_data;
  assign w_in.lo8  = in_lo8;

  assign w_head    = empty ? '0 : r_mem[r_rd];
  assign out_valid = ~empty;
  assign out_tag   = w_head.tag;
  assign out_data  = w_head.data;
  assign out_lo8   = w_head.lo8;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (w_push)
      r_mem[r_wr] <= w_in;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      r_sum <= '0;
    else if (clr)
      r_sum <= '0;
    else if (w_push)
      r_sum <= r_sum + SUM_W'(in_data);
  end

  assign sum = r_sum;

  jit_vec_sat_cnt #(.WIDTH(CNT_W)) u_tag_cnt (
    .clk (sys_clk),
    .rst (sys_rst),
    .inc (w_push & in_tag),
    .clr (clr),
    .q   (tag_cnt)
  );

  jit_vec_sat_cnt #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk (sys_clk),
    .rst (sys_rst),
    .inc (in_valid & ~w_push),
    .clr (clr),
    .q   (drop_cnt)
  );

endmodule
